video_timing_meter: RTL and testbench
=====================================

Name: video_timing_meter

Overview:
- Passive downstream consumer of a video_if stream, e.g. the output of video_dummy or a core's video path, placed before the scaler connection.
- Measures frame geometry: total clocks per line, total lines per frame, active width and active height.
- Tracks lock when consecutive frames match, and counts frames and mismatches.
- Never drives the stream; results feed debug registers and the bridge status block.

Parameters:
- TIMEOUT_CLKS, 65536: clocks without an hs rising edge before lock is dropped and measurement restarts.
- FRAME_CNT_W, 16: width of the frame counter.

Ports:
- rgb_clock  input  1  pixel clock, identical to video.rgb_clock of the monitored stream
- reset_n  input  1  asynchronous active-low reset
- video  input  video_if  monitored stream; rgb, de, skip, vs, hs are read only
- locked  output  1  two consecutive frames measured identical
- frame_strobe  output  1  one-cycle pulse when a completed frame's results are published
- meas  output  video_meas_t  {htotal, vtotal, hactive, vactive}, each count_t (12 bits)
- frame_count  output  FRAME_CNT_W  completed frames since reset, wraps
- error_count  output  8  frame mismatches while locked, saturates at 255

Behaviour:
- Reset (async, reset_n low): all outputs 0, state IDLE, all counters 0. Takes effect immediately mid-frame; locked drops without waiting for a clock.
- Input stage:
  - de, skip, vs and hs are registered once.
  - Rising edges of registered hs and vs define line and frame boundaries.
  - Level widths of hs and vs are irrelevant; vs may stay high for a whole line.
- Line meter:
  - Counts clocks since the last hs edge.
  - Counts pixels where de=1 and skip=0.
  - At each hs edge it emits line_total = clocks since the previous hs edge and line_width = pixel count, then clears both.
  - Counters saturate at 4095.
- Frame accumulation:
  - Each hs edge increments the line count.
  - A line with line_width != 0 increments the active-line count.
  - Its width is compared with the frame's first active line; any difference sets a frame-bad flag.
  - Any line_total different from the frame's first line_total also sets frame-bad.
- Simultaneous hs and vs edges: the frame closes first; the hs edge is line 1 of the new frame.
- States:
  - IDLE: waiting for the first vs edge; the partial frame is discarded. On vs edge -> ACQUIRE with counters cleared.
  - ACQUIRE, at vs edge:
    - Publish results and pulse frame_strobe.
    - If the frame is not bad and results equal the previous published results -> LOCKED.
    - Otherwise stay in ACQUIRE.
  - LOCKED, at vs edge:
    - Publish results and pulse frame_strobe.
    - On mismatch or frame-bad: increment error_count and go -> ACQUIRE, with locked cleared in the same cycle as frame_strobe.
- Timeout: a timeout counter clears on each hs edge. Reaching TIMEOUT_CLKS-1 -> IDLE, locked=0, published meas held, no strobe.
- Latency: frame_strobe, meas, frame_count and locked update 2 rgb_clock edges after the edge at which video.vs is first sampled high.
- Published values:
  - htotal = last line_total of the frame.
  - vtotal = line count.
  - hactive = first active width.
  - vactive = active-line count.
- frame_count increments with every frame_strobe.

Decomposition:
- pocket package gets:
  - count_t, logic [11:0]
  - video_meas_t, a packed struct of four count_t
  - meter_state_t, enum IDLE/ACQUIRE/LOCKED
- Sub-module video_line_meter: input registers, edge detection and per-line clock/pixel counting. Outputs hs_edge, vs_edge, line_total and line_width.

Test Plan:
- video_dummy defaults (740x500), 3 frames:
  - first frame_strobe: meas = {740, 500, 400, 360}, locked=0
  - second strobe: locked=1, frame_count=2
- Locked stream; one line with de held one extra clock (401 pixels) -> next strobe: locked=0, error_count=1; following frame relocks.
- Drive skip=1 on 10 cycles inside each active line -> hactive=390, lock still achieved.
- Stop hs after lock -> locked=0 exactly TIMEOUT_CLKS clocks after the last hs edge (+2 pipeline), state IDLE, meas unchanged.
- Assert reset_n low mid-frame while locked -> all outputs 0 asynchronously; after release, first strobe only after a full frame.
- Force hs and vs rising on the same cycle -> that line is counted in the new frame: vtotal still 500.

Source files
------------

// File: rtl/video_timing_meter_pkg.sv
// video_timing_meter_pkg
// Shared types for the video timing meter: the 12-bit geometry count, the
// published measurement record and the lock state machine encoding.
package video_timing_meter_pkg;

  typedef logic [11:0] count_t;

  localparam count_t COUNT_MAX = '1;

  typedef struct packed {
    count_t htotal;
    count_t vtotal;
    count_t hactive;
    count_t vactive;
  } video_meas_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } meter_state_t;

  // Increment that sticks at the top of the count range instead of wrapping.
  function automatic count_t sat_inc(input count_t v);
    return (v == COUNT_MAX) ? v : v + count_t'(1);
  endfunction

endpackage

// File: rtl/video_timing_meter_if.sv
// video_if
// Video stream bundle. The source drives it through the master modport;
// passive consumers such as the timing meter attach through slave.
//   rgb_clock : pixel clock
//   rgb       : 24-bit pixel data
//   de        : data enable (active pixel)
//   skip      : pixel present but not counted as picture content
//   vs, hs    : vertical / horizontal sync, rising edge marks a boundary
interface video_if;
  logic        rgb_clock;
  logic [23:0] rgb;
  logic        de;
  logic        skip;
  logic        vs;
  logic        hs;

  modport master (output rgb_clock, rgb, de, skip, vs, hs);
  modport slave  (input  rgb_clock, rgb, de, skip, vs, hs);
endinterface

// File: rtl/video_timing_meter_line.sv
// video_line_meter
// Registers the stream control bits, finds hs/vs rising edges and measures
// each line: clocks between hs edges and pixels with de=1, skip=0.
//   i_clk, i_rst_n        : pixel clock, async active-low reset
//   i_de/i_skip/i_vs/i_hs : raw stream control bits
//   o_hs_edge, o_vs_edge  : registered one-cycle edge pulses
//   o_line_total          : clocks in the line just closed (valid with o_hs_edge)
//   o_line_width          : counted pixels in that line (valid with o_hs_edge)
module video_line_meter
  import video_timing_meter_pkg::*;
(
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  logic   i_de,
  input  logic   i_skip,
  input  logic   i_vs,
  input  logic   i_hs,
  output logic   o_hs_edge,
  output logic   o_vs_edge,
  output count_t o_line_total,
  output count_t o_line_width
);

  logic   r_de, r_skip, r_vs, r_hs;
  logic   r_vs_d, r_hs_d;
  count_t r_clk_cnt;
  count_t r_pix_cnt;

  logic w_hs_edge, w_vs_edge, w_pix;

  assign w_hs_edge = r_hs & ~r_hs_d;
  assign w_vs_edge = r_vs & ~r_vs_d;
  assign w_pix     = r_de & ~r_skip;

  // The edge cycle itself closes the line, so its clock and pixel are folded
  // into the emitted totals before the counters restart.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_de         <= 1'b0;
      r_skip       <= 1'b0;
      r_vs         <= 1'b0;
      r_hs         <= 1'b0;
      r_vs_d       <= 1'b0;
      r_hs_d       <= 1'b0;
      r_clk_cnt    <= '0;
      r_pix_cnt    <= '0;
      o_hs_edge    <= 1'b0;
      o_vs_edge    <= 1'b0;
      o_line_total <= '0;
      o_line_width <= '0;
    end else begin
      r_de      <= i_de;
      r_skip    <= i_skip;
      r_vs      <= i_vs;
      r_hs      <= i_hs;
      r_vs_d    <= r_vs;
      r_hs_d    <= r_hs;
      o_hs_edge <= w_hs_edge;
      o_vs_edge <= w_vs_edge;
      if (w_hs_edge) begin
        o_line_total <= sat_inc(r_clk_cnt);
        o_line_width <= w_pix ? sat_inc(r_pix_cnt) : r_pix_cnt;
        r_clk_cnt    <= '0;
        r_pix_cnt    <= '0;
      end else begin
        r_clk_cnt <= sat_inc(r_clk_cnt);
        if (w_pix) begin
          r_pix_cnt <= sat_inc(r_pix_cnt);
        end
      end
    end
  end

endmodule

// File: rtl/video_timing_meter.sv
// video_timing_meter
// Passive monitor of a video_if stream. Measures htotal/vtotal/hactive/
// vactive per frame, publishes them at each vs edge, and locks when two
// consecutive clean frames agree.
//   rgb_clock    : pixel clock of the monitored stream
//   reset_n      : async active-low reset
//   video        : monitored stream (read only)
//   locked       : consecutive frames measured identical
//   frame_strobe : one-cycle pulse when meas is published
//   meas         : {htotal, vtotal, hactive, vactive}
//   frame_count  : published frames since reset, wraps
//   error_count  : mismatching frames while locked, saturates at 255
module video_timing_meter
  import video_timing_meter_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = 65536,
  parameter int unsigned FRAME_CNT_W  = 16
) (
  input  logic                   rgb_clock,
  input  logic                   reset_n,
  video_if.slave                 video,
  output logic                   locked,
  output logic                   frame_strobe,
  output video_meas_t            meas,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [7:0]             error_count
);

  localparam int unsigned   TO_W    = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

  typedef struct packed {
    count_t lines;
    count_t act;
    count_t first_total;
    count_t last_total;
    count_t first_width;
    logic   bad;
  } acc_t;

  logic   w_hs_edge, w_vs_edge;
  count_t w_line_total, w_line_width;

  video_line_meter u_line (
    .i_clk        (rgb_clock),
    .i_rst_n      (reset_n),
    .i_de         (video.de),
    .i_skip       (video.skip),
    .i_vs         (video.vs),
    .i_hs         (video.hs),
    .o_hs_edge    (w_hs_edge),
    .o_vs_edge    (w_vs_edge),
    .o_line_total (w_line_total),
    .o_line_width (w_line_width)
  );

  meter_state_t    r_state;
  acc_t            r_acc;
  logic [TO_W-1:0] r_to_cnt;

  acc_t        w_base, w_next;
  video_meas_t w_res;
  logic        w_match, w_timeout;

  // A vs edge closes the running frame before a coincident hs edge is
  // applied, so that hs edge becomes line 1 of the new frame.
  always_comb begin
    w_base = w_vs_edge ? acc_t'('0) : r_acc;
    w_next = w_base;
    if (w_hs_edge) begin
      w_next.lines      = sat_inc(w_base.lines);
      w_next.last_total = w_line_total;
      if (w_base.lines == '0) begin
        w_next.first_total = w_line_total;
      end else if (w_line_total != w_base.first_total) begin
        w_next.bad = 1'b1;
      end
      if (w_line_width != '0) begin
        w_next.act = sat_inc(w_base.act);
        if (w_base.act == '0) begin
          w_next.first_width = w_line_width;
        end else if (w_line_width != w_base.first_width) begin
          w_next.bad = 1'b1;
        end
      end
    end
  end

  assign w_res     = '{htotal:  r_acc.last_total,
                       vtotal:  r_acc.lines,
                       hactive: r_acc.first_width,
                       vactive: r_acc.act};
  assign w_match   = !r_acc.bad && (w_res == meas);
  assign w_timeout = !w_hs_edge && (r_to_cnt == TO_LAST);

  always_ff @(posedge rgb_clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_acc        <= '0;
      r_to_cnt     <= '0;
      locked       <= 1'b0;
      frame_strobe <= 1'b0;
      meas         <= '0;
      frame_count  <= '0;
      error_count  <= '0;
    end else begin
      frame_strobe <= 1'b0;
      r_acc        <= w_next;

      if (w_hs_edge || w_timeout) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end

      // Timeout drops lock without publishing; meas keeps its last value.
      if (w_timeout) begin
        r_state <= IDLE;
        locked  <= 1'b0;
      end else if (w_vs_edge) begin
        case (r_state)
          IDLE: begin
            r_state <= ACQUIRE;
          end
          ACQUIRE: begin
            meas         <= w_res;
            frame_strobe <= 1'b1;
            frame_count  <= frame_count + FRAME_CNT_W'(1);
            if (w_match) begin
              r_state <= LOCKED;
              locked  <= 1'b1;
            end
          end
          LOCKED: begin
            meas         <= w_res;
            frame_strobe <= 1'b1;
            frame_count  <= frame_count + FRAME_CNT_W'(1);
            if (!w_match) begin
              r_state <= ACQUIRE;
              locked  <= 1'b0;
              if (error_count != 8'hFF) begin
                error_count <= error_count + 8'd1;
              end
            end
          end
          default: begin
            r_state <= IDLE;
            locked  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_video_timing_meter.sv
module tb_video_timing_meter;
  import video_timing_meter_pkg::*;

  localparam int unsigned TO     = 128;
  localparam int          HTOT   = 40;
  localparam int          HS_W   = 4;
  localparam int          HSTART = 8;
  localparam int          HACT   = 20;
  localparam int          VTOT   = 20;
  localparam int          VSTART = 3;
  localparam int          VACT   = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  video_if vif ();
  assign vif.rgb_clock = clk;

  logic        locked, frame_strobe;
  video_meas_t meas;
  logic [15:0] frame_count;
  logic [7:0]  error_count;

  video_timing_meter #(.TIMEOUT_CLKS(TO), .FRAME_CNT_W(16)) dut (
    .rgb_clock    (clk),
    .reset_n      (rst_n),
    .video        (vif),
    .locked       (locked),
    .frame_strobe (frame_strobe),
    .meas         (meas),
    .frame_count  (frame_count),
    .error_count  (error_count)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned last_hs  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    video_meas_t meas;
    logic        locked;
    int unsigned fc;
    int unsigned ec;
    int unsigned due;
  } exp_t;
  exp_t sbq[$];

  // Reference model of the lock behaviour, fed only with what the bench drove.
  meter_state_t m_state = IDLE;
  video_meas_t  m_meas  = '0;
  int unsigned  m_fc = 0, m_ec = 0;
  video_meas_t  pend_res = '0;
  logic         pend_bad = 1'b1;
  logic         irregular = 1'b1;

  task automatic model_vs();
    exp_t e;
    logic lk;
    if (m_state == IDLE) begin
      m_state = ACQUIRE;
    end else begin
      lk = !pend_bad && (pend_res == m_meas);
      if (m_state == LOCKED && !lk && m_ec < 255) m_ec++;
      m_state = lk ? LOCKED : ACQUIRE;
      m_meas  = pend_res;
      m_fc    = (m_fc + 1) & 16'hFFFF;
      e.meas = m_meas; e.locked = lk; e.fc = m_fc; e.ec = m_ec;
      e.due  = cyc + 3;
      sbq.push_back(e);
    end
  endtask

  task automatic drive_frame(input int skipn, input int extra_line);
    int de_end;
    logic act;
    for (int l = 0; l < VTOT; l++) begin
      for (int p = 0; p < HTOT; p++) begin
        @(negedge clk);
        if (l == 0 && p == 0) begin
          model_vs();
          pend_res = '{htotal: count_t'(HTOT), vtotal: count_t'(VTOT),
                       hactive: count_t'(HACT - skipn), vactive: count_t'(VACT)};
          pend_bad  = irregular || (extra_line >= 0);
          irregular = 1'b0;
        end
        if (p == 0) last_hs = cyc + 1;
        act      = (l >= VSTART) && (l < VSTART + VACT);
        de_end   = HSTART + HACT + ((l == extra_line) ? 1 : 0);
        vif.hs   = (p < HS_W);
        vif.vs   = (l < 2);
        vif.de   = act && (p >= HSTART) && (p < de_end);
        vif.skip = vif.de && (skipn > 0) && (p >= HSTART + 5) && (p < HSTART + 5 + skipn);
        vif.rgb  = 24'(l * 256 + p);
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vif.hs = 1'b0; vif.vs = 1'b0; vif.de = 1'b0; vif.skip = 1'b0;
    end
  endtask

  // Strobe monitor: every strobe must match the head of the scoreboard at
  // the cycle it is due; an overdue head is a missing strobe.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && frame_strobe) begin
        if (sbq.size() == 0) begin
          check("strobe_spurious", frame_strobe, 0);
        end else begin
          e = sbq.pop_front();
          check("strobe_cycle", cyc, e.due);
          check("htotal", meas.htotal, e.meas.htotal);
          check("vtotal", meas.vtotal, e.meas.vtotal);
          check("hactive", meas.hactive, e.meas.hactive);
          check("vactive", meas.vactive, e.meas.vactive);
          check("locked", locked, e.locked);
          check("frame_count", frame_count, e.fc);
          check("error_count", error_count, e.ec);
        end
      end else if (rst_n && sbq.size() > 0 && cyc > sbq[0].due) begin
        check("strobe_missing", frame_strobe, 1);
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    video_meas_t saved;
    vif.hs = 1'b0; vif.vs = 1'b0; vif.de = 1'b0; vif.skip = 1'b0; vif.rgb = '0;
    repeat (3) @(negedge clk);
    check("rst_locked", locked, 0);
    check("rst_strobe", frame_strobe, 0);
    check("rst_meas", meas, 0);
    check("rst_fc", frame_count, 0);
    check("rst_ec", error_count, 0);
    rst_n = 1'b1;
    idle_cycles(5);

    repeat (3) drive_frame(0, -1);       // acquire then lock
    drive_frame(0, 6);                   // one 21-pixel line
    repeat (2) drive_frame(0, -1);       // error then relock
    repeat (3) drive_frame(10, -1);      // skipped pixels shrink hactive
    repeat (4) drive_frame(0, -1);       // back to nominal width
    check("pre_timeout_locked", locked, 1);

    saved = meas;
    n = 0;
    while (locked && n < int'(TO) + 60) begin
      @(negedge clk);
      vif.hs = 1'b0; vif.vs = 1'b0; vif.de = 1'b0;
      n++;
    end
    check("timeout_latency", cyc - last_hs, TO + 2);
    check("timeout_meas_held", meas, saved);
    check("timeout_fc_held", frame_count, m_fc);
    m_state = IDLE;
    irregular = 1'b1;
    idle_cycles(20);

    repeat (3) drive_frame(0, -1);       // first vs discarded, then relock
    check("pre_reset_locked", locked, 1);
    fork
      drive_frame(0, -1);
      begin
        repeat (8 * HTOT + 20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_locked", locked, 0);
        check("async_rst_strobe", frame_strobe, 0);
        check("async_rst_meas", meas, 0);
        check("async_rst_fc", frame_count, 0);
        check("async_rst_ec", error_count, 0);
        m_state = IDLE; m_meas = '0; m_fc = 0; m_ec = 0;
        sbq.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    repeat (3) drive_frame(0, -1);
    idle_cycles(10);

    check("scoreboard_drained", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
